// File: rtl/mod_sha256_msg_sched.sv
// SHA-256 message schedule: loads a 16-word block, then streams W[0..63]
// through a 16-word sliding window with a valid/ready handshake on both sides.
module mod_sha256_msg_sched (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] IN_WORD,
  output logic        W_VALID,
  input  logic        W_READY,
  output logic [31:0] W_DATA,
  output logic [5:0]  W_IDX,
  output logic        W_LAST
);

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] win_q [16];
  logic [31:0] win_d [16];
  logic [5:0]  cnt_q, cnt_d;
  logic        in_hs, w_hs;
  logic [31:0] new_w;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  assign IN_READY = (state_q == ST_LOAD);
  assign W_VALID  = (state_q == ST_EMIT);
  assign W_DATA   = W_VALID ? win_q[0] : 32'h0;
  assign W_IDX    = W_VALID ? cnt_q : 6'd0;
  assign W_LAST   = W_VALID && (cnt_q == 6'd63);

  assign in_hs = IN_READY && IN_VALID;
  assign w_hs  = W_VALID && W_READY;
  // Window slot 0 holds W[t], so W[t+16] draws from t+14, t+9, t+1 and t
  assign new_w = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    if (in_hs) begin
      win_d[cnt_q[3:0]] = IN_WORD;
      if (cnt_q == 6'd15) begin
        cnt_d   = 6'd0;
        state_d = ST_EMIT;
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end else if (w_hs) begin
      for (int i = 0; i < 15; i++) begin
        win_d[i] = win_q[i+1];
      end
      win_d[15] = new_w;
      if (cnt_q == 6'd63) begin
        cnt_d   = 6'd0;
        state_d = ST_LOAD;
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_LOAD;
      cnt_q   <= 6'd0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= 32'h0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

endmodule

// File: tb/tb_mod_sha256_msg_sched.sv
// Randomized bench for mod_sha256_msg_sched against a direct W[t] recurrence model.
module tb_mod_sha256_msg_sched;

  logic        CLK;
  logic        RST_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN_WORD;
  logic        W_VALID;
  logic        W_READY;
  logic [31:0] W_DATA;
  logic [5:0]  W_IDX;
  logic        W_LAST;

  mod_sha256_msg_sched dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .IN_WORD  (IN_WORD),
    .W_VALID  (W_VALID),
    .W_READY  (W_READY),
    .W_DATA   (W_DATA),
    .W_IDX    (W_IDX),
    .W_LAST   (W_LAST)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_err = 0;
  int n_chk = 0;

  logic [31:0] blk   [16];
  logic [31:0] ref_w [64];
  logic [31:0] obs_w [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] msig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] msig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_ref();
    for (int t = 0; t < 16; t++) ref_w[t] = blk[t];
    for (int t = 16; t < 64; t++)
      ref_w[t] = msig1(ref_w[t-2]) + ref_w[t-7] + msig0(ref_w[t-15]) + ref_w[t-16];
  endtask

  task automatic load_block(input int gmin, input int gmax);
    for (int i = 0; i < 16; i++) begin
      int g;
      g = int'($urandom_range(gmax, gmin));
      repeat (g) begin
        @(negedge CLK);
        IN_VALID = 1'b0;
        W_READY  = 1'($urandom_range(1, 0));
        chk("in_ready_gap", 32'(IN_READY), 32'd1);
        chk("w_valid_gap", 32'(W_VALID), 32'd0);
      end
      @(negedge CLK);
      chk("in_ready_load", 32'(IN_READY), 32'd1);
      chk("w_valid_load", 32'(W_VALID), 32'd0);
      chk("w_last_load", 32'(W_LAST), 32'd0);
      IN_VALID = 1'b1;
      IN_WORD  = blk[i];
      W_READY  = 1'($urandom_range(1, 0));
    end
    @(negedge CLK);
    IN_VALID = 1'b0;
    IN_WORD  = $urandom;
    chk("w_valid_one_after_load", 32'(W_VALID), 32'd1);
    chk("in_ready_off", 32'(IN_READY), 32'd0);
  endtask

  // Starts at the negedge where load_block left off.
  task automatic emit_block(input bit rand_rdy, input bit hold_iv, input int stop_at);
    int idx = 0;
    int cyc = 0;
    while (idx < 64 && idx != stop_at) begin
      if (cyc > 2000) begin
        chk("emit_timeout", 32'(idx), 32'd64);
        break;
      end
      cyc++;
      chk("w_valid", 32'(W_VALID), 32'd1);
      chk("in_ready_emit", 32'(IN_READY), 32'd0);
      chk("w_idx", 32'(W_IDX), 32'(idx));
      chk("w_data", W_DATA, ref_w[idx]);
      chk("w_last", 32'(W_LAST), 32'(idx == 63));
      W_READY  = rand_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
      IN_VALID = hold_iv;
      IN_WORD  = $urandom;
      if (W_READY) begin
        obs_w[idx] = W_DATA;
        idx++;
      end
      @(negedge CLK);
    end
    IN_VALID = 1'b0;
    if (stop_at >= 64) begin
      chk("handshakes", 32'(idx), 32'd64);
      chk("in_ready_after_last", 32'(IN_READY), 32'd1);
      chk("w_valid_after_last", 32'(W_VALID), 32'd0);
      chk("w_last_after_last", 32'(W_LAST), 32'd0);
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic set_random();
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(IN_READY), 32'd1);
    chk({tag, "_w_valid"}, 32'(W_VALID), 32'd0);
    chk({tag, "_w_data"}, W_DATA, 32'h0);
    chk({tag, "_w_idx"}, 32'(W_IDX), 32'd0);
    chk({tag, "_w_last"}, 32'(W_LAST), 32'd0);
  endtask

  initial begin
    RST_N    = 1'b0;
    IN_VALID = 1'b0;
    IN_WORD  = 32'h0;
    W_READY  = 1'b0;
    #2;
    chk_reset_outputs("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    // "abc" block, always ready
    set_abc();
    build_ref();
    load_block(0, 0);
    emit_block(1'b0, 1'b0, 64);
    chk("abc_w0", obs_w[0], 32'h61626380);
    chk("abc_w15", obs_w[15], 32'h00000018);
    chk("abc_w16", obs_w[16], 32'h61626380);
    chk("abc_w17", obs_w[17], 32'h000F0000);
    chk("abc_w18", obs_w[18], 32'h7DA86405);
    chk("abc_w19", obs_w[19], 32'h600003C6);
    chk("abc_w63", obs_w[63], 32'h12B1EDEB);

    // Same block, random stalls and 1-3 cycle input gaps
    load_block(1, 3);
    emit_block(1'b1, 1'b0, 64);

    // Reset mid-emit, then a fresh random block
    set_random();
    build_ref();
    load_block(0, 2);
    emit_block(1'b1, 1'b0, 30);
    chk("pre_reset_idx", 32'(W_IDX), 32'd30);
    RST_N = 1'b0;
    #1;
    chk_reset_outputs("mid_emit_reset");
    @(negedge CLK);
    RST_N = 1'b1;
    set_random();
    build_ref();
    load_block(0, 1);
    emit_block(1'b1, 1'b0, 64);

    // Back-to-back: abc with IN_VALID held during emit, then all-ones
    set_abc();
    build_ref();
    load_block(0, 0);
    emit_block(1'b1, 1'b1, 64);
    for (int i = 0; i < 16; i++) blk[i] = 32'hFFFFFFFF;
    build_ref();
    load_block(0, 0);
    emit_block(1'b1, 1'b0, 64);
    chk("ones_w0", obs_w[0], 32'hFFFFFFFF);
    chk("ones_w15", obs_w[15], 32'hFFFFFFFF);
    chk("ones_w16", obs_w[16], ref_w[16]);

    // Random blocks with random gaps and stalls
    for (int b = 0; b < 4; b++) begin
      set_random();
      build_ref();
      load_block(0, 3);
      emit_block(1'b1, b[0], 64);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
